// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem_loader
// Purpose  : boot loader packing a byte stream into IMEM words, then running
//            the CPU for MAX_CYCLES. Option: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              start_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int              PTR_W      = ADDR_W + 1;
  localparam logic [PTR_W-1:0] C_DEPTH   = PTR_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] C_LAST_CYC = CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);
  localparam bit              C_BOUNDED  = (MAX_CYCLES != 0);

  localparam logic [2:0] C_ST_LOAD  = 3'd0;
  localparam logic [2:0] C_ST_PAD   = 3'd1;
  localparam logic [2:0] C_ST_FLUSH = 3'd2;
  localparam logic [2:0] C_ST_RUN   = 3'd3;
  localparam logic [2:0] C_ST_HALT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic [31:0]       w_word;
  logic              w_commit;
  logic [31:0]       w_commit_word;

  // Byte 0 clears the upper lanes, so a short final word is already zero-padded.
  always_comb begin
    w_word = (byte_idx_q == 2'd0) ? 32'h0 : asm_q;
    w_word[{byte_idx_q, 3'b000} +: 8] = load_data_i;
  end

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    ptr_d         = ptr_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    w_commit      = 1'b0;
    w_commit_word = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      C_ST_LOAD: begin
        if (load_valid_i) begin
          asm_d      = w_word;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            w_commit      = 1'b1;
            w_commit_word = w_word;
          end
          if (load_last_i) begin
            byte_idx_d = 2'd0;
            state_d    = (byte_idx_q == 2'd3) ? C_ST_FLUSH : C_ST_PAD;
          end
        end
      end
      C_ST_PAD: begin
        w_commit = 1'b1;
        state_d  = C_ST_FLUSH;
      end
      C_ST_FLUSH: state_d = C_ST_RUN;
      C_ST_RUN: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (C_BOUNDED && (cnt_q == C_LAST_CYC)) state_d = C_ST_HALT;
      end
      C_ST_HALT: state_d = C_ST_HALT;
      default:   state_d = C_ST_LOAD;
    endcase

    // A full memory swallows further words and latches the overflow flag.
    if (w_commit) begin
      if (ptr_q == C_DEPTH) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q[ADDR_W-1:0];
        wdata_d = w_commit_word;
        ptr_d   = ptr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q + w_commit_word;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= C_ST_LOAD;
      byte_idx_q <= 2'd0;
      asm_q      <= 32'h0;
      ptr_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      ptr_q      <= ptr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign load_ready_o = (state_q == C_ST_LOAD);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign start_o      = (state_q == C_ST_RUN);
  assign done_o       = (state_q == C_ST_HALT);
  assign err_o        = err_q;
  assign cycle_cnt_o  = cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum_o   = csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : scoreboard bench for imem_loader (default and 4-word-deep copies)
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic [7:0]  load_data_i = 8'h0;
  logic        load_last_i = 1'b0;

  logic        m_ready, m_we, m_start, m_done, m_err;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [15:0] m_cnt;
  logic        v_ready, v_we, v_start, v_done, v_err;
  logic [1:0]  v_addr;
  logic [31:0] v_wdata;
  logic [15:0] v_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] m_csum, v_csum;
`endif

  imem_loader #(.IMEM_DEPTH(256), .ADDR_W(8), .MAX_CYCLES(30), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_last_i(load_last_i), .load_ready_o(m_ready), .imem_we_o(m_we), .imem_addr_o(m_addr),
    .imem_wdata_o(m_wdata), .start_o(m_start), .done_o(m_done), .err_o(m_err),
    .cycle_cnt_o(m_cnt)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum_o(m_csum)
`endif
  );

  imem_loader #(.IMEM_DEPTH(4), .ADDR_W(2), .MAX_CYCLES(5), .CNT_W(16)) dut_ovf (
    .clk_i(clk_i), .rst_i(rst_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_last_i(load_last_i), .load_ready_o(v_ready), .imem_we_o(v_we), .imem_addr_o(v_addr),
    .imem_wdata_o(v_wdata), .start_o(v_start), .done_o(v_done), .err_o(v_err),
    .cycle_cnt_o(v_cnt)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum_o(v_csum)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [39:0] q_main[$];
  logic [39:0] q_ovf[$];
  logic [7:0]  prog[$];
  logic [39:0] exp_m, exp_v;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Write monitors: every strobe must match the head of its expectation queue.
  always @(negedge clk_i) begin
    if (m_we === 1'b1) begin
      if (q_main.size() == 0) check("main_extra_write", 64'(q_main.size()), 64'd1);
      else begin
        exp_m = q_main.pop_front();
        check("main_write", {m_addr, m_wdata}, exp_m);
      end
    end
    if (v_we === 1'b1) begin
      if (q_ovf.size() == 0) check("ovf_extra_write", 64'(q_ovf.size()), 64'd1);
      else begin
        exp_v = q_ovf.pop_front();
        check("ovf_write", {6'd0, v_addr, v_wdata}, exp_v);
      end
    end
  end

  task automatic add4(input logic [31:0] w);
    for (int b = 0; b < 4; b++) prog.push_back(w[8*b +: 8]);
  endtask

  task automatic add_rand(input int n);
    for (int b = 0; b < n; b++) prog.push_back(8'($urandom));
  endtask

  // Pushes expected writes for the stream, then drives it byte by byte.
  task automatic send(input bit with_last, input bit gaps);
    int          nw;
    int          tries;
    logic [31:0] w;
    nw = with_last ? (prog.size() + 3) / 4 : prog.size() / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4*i + b < prog.size()) w[8*b +: 8] = prog[4*i + b];
      q_main.push_back({8'(i), w});
      if (i < 4) q_ovf.push_back({8'(i), w});
    end
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps) begin
        for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
          @(negedge clk_i);
          load_valid_i = 1'b0;
          load_data_i  = 8'($urandom);
          load_last_i  = 1'($urandom);
        end
      end
      @(negedge clk_i);
      load_valid_i = 1'b1;
      load_data_i  = prog[i];
      load_last_i  = with_last && (i == prog.size() - 1);
      tries = 0;
      while (m_ready !== 1'b1 && tries < 20) begin
        @(negedge clk_i);
        tries++;
      end
      if (m_ready !== 1'b1) begin
        check("send_ready_timeout", 64'(m_ready), 64'd1);
        load_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 12 && m_start !== 1'b1; i++) @(negedge clk_i);
    check("run_entered", 64'(m_start), 64'd1);
    check("run_cnt_start", 64'(m_cnt), 64'd0);
  endtask

  task automatic do_reset();
    check("main_pending", 64'(q_main.size()), 64'd0);
    check("ovf_pending", 64'(q_ovf.size()), 64'd0);
    q_main.delete();
    q_ovf.delete();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    prog.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {m_ready, m_we, m_start, m_done, m_err}, 5'b10000);
    check({tag, "_addr_data_cnt"}, {m_addr, m_wdata, m_cnt}, 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, m_csum, 64'd0);
`endif
  endtask

  int run_cycles;

  initial begin
    // reset state while rst_i is held low
    #12;
    check_reset_outputs("reset");
    check("reset_ovf_flags", {v_ready, v_we, v_start, v_done, v_err}, 5'b10000);
    @(negedge clk_i);
    rst_i = 1'b1;

    // two-word program, last on byte 8
    add4(32'h00500513);
    add4(32'h00A00593);
    send(1'b1, 1'b0);
    @(negedge clk_i);
    check("t1_write_cycle", {m_ready, m_we, m_start}, 3'b010);
    @(negedge clk_i);
    check("t1_start_after_write", {m_we, m_start}, 2'b01);
    check("t1_hold_addr_data", {m_addr, m_wdata}, {8'd1, 32'h00A00593});
    check("t1_ovf_start", 64'(v_start), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t1_checksum", m_csum, 32'h00F00AA6);
`endif

    // run budget of 30 cycles, then halt with count held
    run_cycles = 1;
    for (int i = 0; i < 100 && m_done !== 1'b1; i++) begin
      @(negedge clk_i);
      if (m_start === 1'b1) run_cycles++;
    end
    check("t3_start_cycles", 64'(run_cycles), 64'd30);
    check("t3_halt_flags", {m_start, m_done}, 2'b01);
    check("t3_cnt", 64'(m_cnt), 64'd30);
    repeat (5) @(negedge clk_i);
    check("t3_cnt_held", {m_start, m_done, m_cnt}, {2'b01, 16'd30});
    check("t3_ovf_halt", {v_done, v_cnt}, {1'b1, 16'd5});

    // six bytes: short last word is zero padded after one PAD cycle
    do_reset();
    add4(32'h44332211);
    prog.push_back(8'hAA);
    prog.push_back(8'hBB);
    send(1'b1, 1'b0);
    @(negedge clk_i);
    check("t2_pad_cycle", {m_ready, m_we, m_start}, 3'b000);
    @(negedge clk_i);
    check("t2_pad_write", {m_we, m_start}, 2'b10);
    @(negedge clk_i);
    check("t2_run", 64'(m_start), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_checksum", m_csum, 32'h4433DDBB);
`endif

    // same random image gap-free and with 50% valid gaps
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] img[$];
      if (pass == 0) begin
        do_reset();
        add_rand(14);
        img = prog;
      end else begin
        img = prog;
        do_reset();
        prog = img;
      end
      send(1'b1, 1'(pass));
      wait_run();
    end

    // five words into a four-word memory
    do_reset();
    add_rand(20);
    send(1'b1, 1'b0);
    wait_run();
    check("t5_ovf_err_run", {v_err, v_start}, 2'b11);
    check("t5_ovf_hold_addr", 64'(v_addr), 64'd3);
    check("t5_main_no_err", 64'(m_err), 64'd0);

    // reset mid-word, then reload from address 0
    do_reset();
    add_rand(10);
    send(1'b0, 1'b0);
    @(negedge clk_i);
    check("t6_pre_rst_addr", 64'(m_addr), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    check_reset_outputs("t6_async_mid_word");
    @(negedge clk_i);
    rst_i = 1'b1;
    prog.delete();
    add4(32'h00500513);
    add4(32'h00A00593);
    send(1'b1, 1'b0);
    wait_run();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t6_checksum", m_csum, 32'h00F00AA6);
`endif

    // reset mid-run
    repeat (4) @(negedge clk_i);
    check("t6_run_cnt", {m_start, m_cnt}, {1'b1, 16'd4});
    #2 rst_i = 1'b0;
    #1;
    check_reset_outputs("t6_async_mid_run");
    @(negedge clk_i);
    rst_i = 1'b1;
    check("final_main_pending", 64'(q_main.size()), 64'd0);
    check("final_ovf_pending", 64'(q_ovf.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
